// File: rtl/demultiplexer.sv
// Streaming 1-to-2 demultiplexer: routes each accepted word to channel x (s=0) or y (s=1),
// each channel buffered by its own FIFO so the two consumers stall independently.
module demultiplexer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             d_valid_i,
  output logic             d_ready_o,
  input  logic [WIDTH-1:0] d_i,
  input  logic             s_i,
  output logic             x_valid_o,
  input  logic             x_ready_i,
  output logic [WIDTH-1:0] x_o,
  output logic [LW-1:0]    x_level_o,
  output logic             y_valid_o,
  input  logic             y_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic [LW-1:0]    y_level_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [1:0]       push, pop, full, nempty, rdy;
  logic [WIDTH-1:0] head  [2];
  logic [LW-1:0]    level [2];

  assign rdy = {y_ready_i, x_ready_i};

  // No pass-through on full: a pop in the same cycle does not free the slot.
  assign d_ready_o = s_i ? !full[1] : !full[0];
  assign push[0]   = d_valid_i && d_ready_o && !s_i;
  assign push[1]   = d_valid_i && d_ready_o && s_i;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    lvl_q;

    assign full[c]   = (lvl_q == LW'(DEPTH));
    assign nempty[c] = (lvl_q != '0);
    assign pop[c]    = nempty[c] && rdy[c];
    assign head[c]   = nempty[c] ? mem_q[rd_q] : '0;
    assign level[c]  = lvl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_q  <= '0;
        rd_q  <= '0;
        lvl_q <= '0;
      end else begin
        if (push[c]) wr_q <= wr_q + 1'b1;
        if (pop[c])  rd_q <= rd_q + 1'b1;
        if (push[c] && !pop[c]) begin
          lvl_q <= lvl_q + 1'b1;
        end else if (pop[c] && !push[c]) begin
          lvl_q <= lvl_q - 1'b1;
        end
      end
    end

    // Storage needs no reset: stale entries are masked by the level counter.
    always_ff @(posedge clk_i) begin
      if (push[c]) mem_q[wr_q] <= d_i;
    end
  end

  assign x_valid_o = nempty[0];
  assign y_valid_o = nempty[1];
  assign x_o       = head[0];
  assign y_o       = head[1];
  assign x_level_o = level[0];
  assign y_level_o = level[1];

endmodule

// File: tb/tb_demultiplexer.sv
// Directed, table-driven bench for the 1-to-2 streaming demultiplexer.
module tb_demultiplexer;

  logic        clk, rst_n;
  logic        d_valid, d_ready, s;
  logic [63:0] d;
  logic        x_valid, x_ready, y_valid, y_ready;
  logic [63:0] x, y;
  logic [1:0]  x_level, y_level;

  int checks = 0;
  int errors = 0;
  logic [63:0] xq[$];
  logic [63:0] yq[$];

  demultiplexer #(.WIDTH(64), .DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .d_valid_i(d_valid), .d_ready_o(d_ready), .d_i(d), .s_i(s),
    .x_valid_o(x_valid), .x_ready_i(x_ready), .x_o(x), .x_level_o(x_level),
    .y_valid_o(y_valid), .y_ready_i(y_ready), .y_o(y), .y_level_o(y_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word that is popped at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && x_valid && x_ready) xq.push_back(x);
    if (rst_n && y_valid && y_ready) yq.push_back(y);
  end

  typedef struct {
    logic dv; logic s; logic [63:0] d; logic xr; logic yr;
    logic dr; logic xv; logic [63:0] x; logic [1:0] xl;
    logic yv; logic [63:0] y; logic [1:0] yl;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic xv, input logic [63:0] xe,
                          input logic [1:0] xl, input logic yv, input logic [63:0] ye,
                          input logic [1:0] yl);
    chk({tag, " x_valid"}, 64'(x_valid), 64'(xv));
    chk({tag, " x"}, x, xe);
    chk({tag, " x_level"}, 64'(x_level), 64'(xl));
    chk({tag, " y_valid"}, 64'(y_valid), 64'(yv));
    chk({tag, " y"}, y, ye);
    chk({tag, " y_level"}, 64'(y_level), 64'(yl));
  endtask

  task automatic drain_chk(input string tag, input logic is_x, input logic [63:0] exp[$]);
    logic [63:0] got[$];
    got = is_x ? xq : yq;
    chk({tag, " count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s word%0d", tag, i), got[i], exp[i]);
    end
  endtask

  initial begin
    int cnt, sent, max_lvl;
    logic acc;
    logic [63:0] exp[$];

    //          dv    s     d                      xr    yr  | dr    xv    x      xl    yv    y      yl
    vecs[0]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 64'd0, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 2'd0, 1'b1, 64'd0, 2'd1};
    vecs[2]  = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 64'd1, 1'b0, 1'b1, 1'b1, 1'b1, 64'd1, 2'd1, 1'b0, 64'd0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 64'd2, 1'b0, 1'b1, 1'b1, 1'b1, 64'd1, 2'd2, 1'b0, 64'd0, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 64'd3, 1'b0, 1'b1, 1'b0, 1'b1, 64'd1, 2'd2, 1'b0, 64'd0, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 64'd3, 1'b0, 1'b1, 1'b1, 1'b1, 64'd1, 2'd2, 1'b0, 64'd0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 64'd3, 1'b1, 1'b1, 1'b0, 1'b1, 64'd2, 2'd1, 1'b0, 64'd0, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 64'd3, 1'b0, 1'b1, 1'b1, 1'b1, 64'd2, 2'd2, 1'b0, 64'd0, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'd3, 2'd1, 1'b0, 64'd0, 2'd0};
    vecs[10] = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0, 2'd0};

    rst_n = 1'b1; d_valid = 1'b0; s = 1'b0; d = '0; x_ready = 1'b0; y_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset d_ready", 64'(d_ready), 64'd1);
    chk_outs("reset", 1'b0, 64'd0, 2'd0, 1'b0, 64'd0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Route, backpressure and full-with-pop vectors.
    for (int i = 0; i < 11; i++) begin
      d_valid = vecs[i].dv; s = vecs[i].s; d = vecs[i].d;
      x_ready = vecs[i].xr; y_ready = vecs[i].yr;
      #1;
      chk($sformatf("v%0d d_ready", i), 64'(d_ready), 64'(vecs[i].dr));
      tick();
      chk_outs($sformatf("v%0d", i), vecs[i].xv, vecs[i].x, vecs[i].xl,
               vecs[i].yv, vecs[i].y, vecs[i].yl);
    end

    // Interleave: y stalls, blocking the input at word 5 until y drains.
    xq.delete(); yq.delete();
    x_ready = 1'b1; y_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_valid = 1'b1; d = 64'(i); s = i[0];
      #1;
      if (i == 5) begin
        chk("ilv stall d_ready", 64'(d_ready), 64'd0);
        chk("ilv stall y_level", 64'(y_level), 64'd2);
        y_ready = 1'b1;
      end
      cnt = 0;
      while (!d_ready && cnt < 20) begin
        tick();
        cnt++;
      end
      if (cnt == 20) begin
        errors++;
        $display("FAIL ilv timeout: word %0d never accepted", i);
      end
      tick();
    end
    d_valid = 1'b0;
    repeat (4) tick();
    exp = '{64'd0, 64'd2, 64'd4, 64'd6};
    drain_chk("ilv x", 1'b1, exp);
    exp = '{64'd1, 64'd3, 64'd5, 64'd7};
    drain_chk("ilv y", 1'b0, exp);

    // Wrap: 10 words to x with the consumer ready every other cycle.
    xq.delete(); yq.delete();
    sent = 0; max_lvl = 0;
    for (int c = 0; c < 100 && sent < 10; c++) begin
      x_ready = c[0]; d_valid = 1'b1; s = 1'b0; d = 64'(sent);
      #1;
      acc = d_ready;
      tick();
      if (acc) sent++;
      if (int'(x_level) > max_lvl) max_lvl = int'(x_level);
    end
    d_valid = 1'b0; x_ready = 1'b1;
    repeat (4) tick();
    chk("wrap sent", 64'(sent), 64'd10);
    chk("wrap max level", 64'(max_lvl), 64'd2);
    exp = '{};
    for (int i = 0; i < 10; i++) exp.push_back(64'(i));
    drain_chk("wrap x", 1'b1, exp);

    // Reset mid-operation with both FIFOs holding data.
    x_ready = 1'b0; y_ready = 1'b0; d_valid = 1'b1;
    s = 1'b0; d = 64'hA1; tick();
    s = 1'b0; d = 64'hA2; tick();
    s = 1'b1; d = 64'hB1; tick();
    d_valid = 1'b0; s = 1'b0;
    #1;
    chk("pre-reset x_level", 64'(x_level), 64'd2);
    chk("pre-reset d_ready", 64'(d_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid reset d_ready", 64'(d_ready), 64'd1);
    chk_outs("mid reset", 1'b0, 64'd0, 2'd0, 1'b0, 64'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xq.delete(); yq.delete();
    x_ready = 1'b1; y_ready = 1'b1;
    d_valid = 1'b1; s = 1'b0; d = 64'h55;
    tick();
    d_valid = 1'b0;
    repeat (5) tick();
    exp = '{64'h55};
    drain_chk("post reset x", 1'b1, exp);
    exp = '{};
    drain_chk("post reset y", 1'b0, exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demultiplexer.md
# demultiplexer

Streaming 1-to-2 demultiplexer: the receive-side counterpart of the 64-bit 2:1 multiplexer. It accepts tagged words on a single valid/ready input channel and routes each word to output channel x (s=0) or y (s=1). Each output channel is buffered by its own FIFO, so the two consumers can stall independently. The select polarity matches the multiplexer (s=0 ↔ x, s=1 ↔ y), so a multiplexer/demultiplexer pair round-trips data.

## Interface
- WIDTH, 64, data width of d, x, y
- DEPTH, 2, per-channel FIFO depth in words; power of two, ≥2
- LW (localparam), $clog2(DEPTH)+1, width of the level outputs

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- d_valid  in  1  input word present
- d_ready  out  1  input word can be accepted this cycle
- d  in  WIDTH  input word
- s  in  1  route select; 0 → x, 1 → y; qualified by d_valid
- x_valid  out  1  channel x head word valid
- x_ready  in  1  channel x consumer takes head
- x  out  WIDTH  channel x head word
- x_level  out  LW  words held in x FIFO (0..DEPTH)
- y_valid, y_ready, y, y_level: same as the x signals, for channel y

## Operation
- Accept: d_valid && d_ready at a rising edge; the word is written to the FIFO selected by s.
- d_ready (combinational) = !full(x) when s=0, !full(y) when s=1. It depends only on s and FIFO state, never on d_valid.
- A full selected FIFO blocks the input. This holds even if that FIFO pops in the same cycle: there is no pass-through on full.
- A blocked word must be held stable (d, s) by the producer until it is accepted. Changing s while stalled is legal and re-evaluates d_ready.
- Pop: x_valid && x_ready at a rising edge removes the x head. y behaves the same way.
- x_valid = (x_level != 0). x = head word when x_valid=1, and is forced to all-zero when x_valid=0. y behaves the same way.
- Simultaneous push and pop on the same non-full, non-empty FIFO: level unchanged, order preserved.
- Push to one channel and pop from the other in the same cycle are independent.
- Order is preserved per channel. There is no ordering relation between channels.
- Pointers wrap modulo DEPTH. The level counter never exceeds DEPTH and never underflows.
- Asserting x_ready with x_valid=0 has no effect.
- Reset (asynchronous, any time, including mid-transfer):
  - All FIFOs are emptied; pointers and levels go to 0.
  - Outputs: x_valid=0, y_valid=0, x=0, y=0, x_level=0, y_level=0.
  - d_ready=1 as soon as rst_n=0.
  - Words in flight are discarded.
- There is no state machine beyond the two FIFO pointer/level sets.

## Timing
- Input-to-output latency: a word accepted at edge N is visible on x/y with valid=1 after edge N (cycle N+1). There is no same-cycle bypass.
- Throughput: one word per cycle into each channel while its FIFO is not full and its consumer drains at one word per cycle.
- The level outputs update on the same edge as the push/pop that changes them.
- d_ready is combinational from s and registered state only. There is no path from d_valid, x_ready or y_ready to d_ready.
- Release of rst_n is synchronous to clk from the producer's point of view. The first accept can happen at the first edge after deassertion.

## Test plan
- Route: d=64'hffffffffffffffff, s=0, then d=64'h0, s=1, both consumers ready.
  - Required: x=ffff…ffff with x_valid for one cycle, one cycle after accept.
  - Required: y=0 with y_valid, one cycle after its own accept.
  - Required: the opposite channel stays invalid and reads 0 throughout.
- Backpressure: x_ready=0; send 3 words with s=0 (values 1, 2, 3).
  - Required: x_level reaches 2 and d_ready=0 on the third word.
  - Required: switching s to 1 makes d_ready=1.
  - Required: after raising x_ready, x presents 1 then 2 (then 3 once accepted).
- Full with pop: x FIFO full, x_ready=1, d_valid=1, s=0 in the same cycle.
  - Required: the pop occurs, no push occurs, and x_level goes 2→1.
  - Required: the push is accepted on the next edge.
- Interleave: alternate s=0/1 on 8 words (values 0..7), y_ready=0, x_ready=1.
  - Required: x emits 0, 2, 4, 6; y holds 1, 3 and stalls the input at word 5 with y_level=2.
- Wrap: stream 10 words with s=0 and x_ready toggling every cycle.
  - Required: x outputs exactly 0..9 in order and x_level never exceeds 2.
- Reset mid-operation: both FIFOs hold data; pull rst_n low between edges.
  - Required: all valids, data and levels read 0 and d_ready=1 immediately.
  - Required: after release, the stale words are never emitted.
